// File: rtl/enc3_pkg.sv
// Shared definitions for the encryption-3 / decryption-3 pair: widths,
// frame layout and the boundaries of the mask slices.
package enc3_pkg;

    localparam int unsigned PT_W    = 60;              // plaintext / mask width
    localparam int unsigned SEED_W  = 11;              // rand_11 mask seed
    localparam int unsigned TAG_W   = 6;               // rand_6 pass-through tag
    localparam int unsigned X_W     = PT_W + 1;        // masked value width
    localparam int unsigned FRAME_W = X_W + SEED_W + TAG_W;

    // Frame layout, MSB first: x[77:17], rand_11[16:6], rand_6[5:0]
    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [SEED_W-1:0] r;
        logic [TAG_W-1:0]  tag;
    } frame_t;

    // Lower bit of each mask slice; the top slice ends at PT_W-1
    localparam int unsigned M0_LSB = 0;    // ~r
    localparam int unsigned M1_LSB = 11;   //  r
    localparam int unsigned M2_LSB = 22;   //  r
    localparam int unsigned M3_LSB = 33;   // ~r
    localparam int unsigned M4_LSB = 44;   //  r
    localparam int unsigned M5_LSB = 55;   //  r[4:0]

endpackage

// File: rtl/decrypt_function_3_if.sv
// Streaming valid/ready bundle between the frame deserializer, the
// decryptor and the plaintext consumer.
interface decrypt_function_3_if;
    import enc3_pkg::*;

    logic [FRAME_W-1:0] frame_in;
    logic               in_valid;
    logic               in_ready;
    logic [PT_W-1:0]    data_out;
    logic [TAG_W-1:0]   rand_6_out;
    logic               err_out;
    logic               out_valid;
    logic               out_ready;

    // Decryptor side
    modport slave (
        input  frame_in, in_valid, out_ready,
        output in_ready, data_out, rand_6_out, err_out, out_valid
    );

    // Producer/consumer side
    modport master (
        output frame_in, in_valid, out_ready,
        input  in_ready, data_out, rand_6_out, err_out, out_valid
    );

endinterface

// File: rtl/enc3_mask_gen.sv
// Additive mask generator shared by encryptor and decryptor so both
// directions derive an identical 60-bit mask from the 11-bit seed.
module enc3_mask_gen
    import enc3_pkg::*;
(
    input  logic [SEED_W-1:0] r,
    output logic [PT_W-1:0]   b
);

    // Tile the seed (and its complement) across the mask
    always_comb begin
        b = '0;
        b[M1_LSB-1:M0_LSB] = ~r;
        b[M2_LSB-1:M1_LSB] = r;
        b[M3_LSB-1:M2_LSB] = r;
        b[M4_LSB-1:M3_LSB] = ~r;
        b[M5_LSB-1:M4_LSB] = r;
        b[PT_W-1:M5_LSB]   = r[PT_W-M5_LSB-1:0];
    end

endmodule

// File: rtl/decrypt_function_3.sv
// Two-stage streaming decryptor: S1 captures the frame and its mask,
// S2 subtracts the mask, flags inconsistent frames and presents the
// result. Saturating delivered-frame and error counters.
module decrypt_function_3
    import enc3_pkg::*;
#(
    parameter int unsigned DATA_W = 60,
    parameter int unsigned R11_W  = 11,
    parameter int unsigned R6_W   = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    decrypt_function_3_if.slave bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    frame_t              fin;
    logic [R11_W-1:0]    seed;
    logic [DATA_W-1:0]   mask;

    logic                s1_v;
    logic                s2_v;
    logic                s1_adv;
    logic                s2_adv;
    logic                out_hs;

    logic [DATA_W:0]     s1_x;
    logic [DATA_W-1:0]   s1_b;
    logic [R6_W-1:0]     s1_tag;

    logic [DATA_W+1:0]   diff;

    logic [DATA_W-1:0]   data_q;
    logic [R6_W-1:0]     tag_q;
    logic                err_q;

    assign fin  = bus.frame_in;
    assign seed = fin.r;

    enc3_mask_gen u_mask (
        .r (seed),
        .b (mask)
    );

    assign s2_adv = !s2_v || bus.out_ready;
    assign s1_adv = !s1_v || s2_adv;
    assign out_hs = s2_v && bus.out_ready;

    // Extra top bit catches the borrow, bit DATA_W catches overflow
    assign diff = {1'b0, s1_x} - {2'b0, s1_b};

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_v;
    assign bus.data_out   = data_q;
    assign bus.rand_6_out = tag_q;
    assign bus.err_out    = err_q;

    // S1: capture frame fields and the mask on each input handshake
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_v   <= 1'b0;
            s1_x   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x   <= fin.x;
                s1_b   <= mask;
                s1_tag <= fin.tag;
            end
        end
    end

    // S2: unmask and flag, holding while the consumer stalls
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s2_v   <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                data_q <= diff[DATA_W-1:0];
                tag_q  <= s1_tag;
                err_q  <= diff[DATA_W+1] | diff[DATA_W];
            end
        end
    end

    // Saturating statistics, updated on the output handshake edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (out_hs) begin
            if (frame_cnt != '1)
                frame_cnt <= frame_cnt + CNT_W'(1);
            if (err_q && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
